// File: rtl/t05_sram_pkg.sv
// Shared types and constants for the Huffman-pipeline SRAM arbiter.
// Requester indices name the fixed client map used by the top level.
package t05_sram_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BEAT = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int NODE_W  = 71;
    localparam int BEATS   = 3;
    localparam int WORD_W  = 32;
    localparam int NUM_REQ = 4;

    localparam int REQ_HTREE = 0;
    localparam int REQ_FLV   = 1;
    localparam int REQ_CB    = 2;
    localparam int REQ_HIST  = 3;

endpackage

// File: rtl/t05_rr_arbiter.sv
// Combinational round-robin pick: the first set request at or after ptr,
// wrapping, as one-hot grant plus binary index.
module t05_rr_arbiter
    import t05_sram_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [1:0]         ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic               valid,
    output logic [1:0]         idx
);

    logic [1:0] cand;

    // NOTE: every output of a combinational block gets a default first, so no path leaves one unassigned and infers a latch.
    always_comb begin
        grant = '0;
        valid = 1'b0;
        idx   = '0;
        cand  = '0;
        // Walk offsets from farthest to nearest so the nearest set request is the last one written.
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = ptr + 2'(k);
            if (req[cand]) begin
                valid = 1'b1;
                idx   = cand;
            end
        end
        grant[idx] = valid;
    end

endmodule

// File: rtl/t05_sram_arbiter.sv
// Four-way round-robin arbiter moving one 71-bit node per grant as three
// 32-bit SRAM bus beats, with a per-beat ack timeout.
module t05_sram_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int NODE_W  = 71,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [3:0]          req,
    input  logic [3:0]          rd_nwr,
    input  logic [4*ADDR_W-1:0] req_addr,
    input  logic [4*NODE_W-1:0] req_wdata,
    output logic [3:0]          grant,
    output logic [3:0]          done,
    output logic                err,
    output logic [NODE_W-1:0]   rdata,
    output logic                bus_req,
    output logic                bus_we,
    output logic [ADDR_W-1:0]   bus_addr,
    output logic [31:0]         bus_wdata,
    input  logic                bus_ack,
    input  logic [31:0]         bus_rdata
);
    import t05_sram_pkg::*;

    localparam int TW   = $clog2(TIMEOUT + 1);
    localparam int HI_W = NODE_W - 2 * WORD_W;

    state_t              state;
    logic [1:0]          ptr;
    logic [1:0]          own_idx;
    logic [1:0]          beat;
    logic [1:0]          next_beat;
    logic [TW-1:0]       tcnt;
    logic [ADDR_W-1:0]   base;
    logic                rd;
    logic [NODE_W-1:0]   payload;
    logic [2*WORD_W-1:0] shadow;

    logic [3:0]          pick_grant;
    logic                pick_valid;
    logic [1:0]          pick_idx;
    logic [ADDR_W-1:0]   sel_addr;
    logic [NODE_W-1:0]   sel_wdata;

    t05_rr_arbiter u_rr (
        .req   (req),
        .ptr   (ptr),
        .grant (pick_grant),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    function automatic logic [WORD_W-1:0] beat_word(input logic [NODE_W-1:0] p, input logic [1:0] b);
        logic [WORD_W-1:0] w;
        case (b)
            2'd0:    w = p[WORD_W-1:0];
            2'd1:    w = p[2*WORD_W-1:WORD_W];
            default: w = WORD_W'(p[NODE_W-1:2*WORD_W]);
        endcase
        return w;
    endfunction

    function automatic logic [ADDR_W-1:0] beat_addr(input logic [ADDR_W-1:0] a, input logic [1:0] b);
        return a + ADDR_W'({b, 2'b00});
    endfunction

    assign sel_addr  = req_addr[int'(pick_idx) * ADDR_W +: ADDR_W];
    assign sel_wdata = req_wdata[int'(pick_idx) * NODE_W +: NODE_W];
    assign next_beat = beat + 2'd1;

    // NOTE: all state, including the read shadow, is cleared by the async reset so a dropped transaction leaves nothing stale.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= '0;
            own_idx   <= '0;
            beat      <= '0;
            tcnt      <= '0;
            base      <= '0;
            rd        <= 1'b0;
            payload   <= '0;
            shadow    <= '0;
            grant     <= '0;
            done      <= '0;
            err       <= 1'b0;
            rdata     <= '0;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_wdata <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            done <= '0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        grant     <= pick_grant;
                        own_idx   <= pick_idx;
                        base      <= sel_addr;
                        rd        <= rd_nwr[pick_idx];
                        payload   <= sel_wdata;
                        beat      <= '0;
                        tcnt      <= '0;
                        bus_req   <= 1'b1;
                        bus_we    <= ~rd_nwr[pick_idx];
                        bus_addr  <= sel_addr;
                        bus_wdata <= beat_word(sel_wdata, 2'd0);
                        state     <= BEAT;
                    end
                end
                BEAT: begin
                    if (bus_ack) begin
                        tcnt <= '0;
                        if (beat == 2'(BEATS - 1)) begin
                            // Last word goes straight into rdata; only its low node bits are meaningful.
                            if (rd) rdata <= {bus_rdata[HI_W-1:0], shadow};
                            bus_req <= 1'b0;
                            bus_we  <= 1'b0;
                            done    <= grant;
                            state   <= DONE;
                        end else begin
                            if (rd) begin
                                if (beat == 2'd0) shadow[WORD_W-1:0] <= bus_rdata;
                                else              shadow[2*WORD_W-1:WORD_W] <= bus_rdata;
                            end
                            beat      <= next_beat;
                            bus_addr  <= beat_addr(base, next_beat);
                            bus_wdata <= beat_word(payload, next_beat);
                        end
                    end else if (tcnt == TW'(TIMEOUT - 1)) begin
                        bus_req <= 1'b0;
                        bus_we  <= 1'b0;
                        done    <= grant;
                        err     <= 1'b1;
                        state   <= DONE;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                DONE: begin
                    ptr   <= own_idx + 2'd1;
                    grant <= '0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_t05_sram_arbiter.sv
// Scoreboard bench for t05_sram_arbiter: stimulus queues expected bus beats and
// completions, a negedge monitor pops and compares them against a simple bus slave.
module tb_t05_sram_arbiter;
    import t05_sram_pkg::*;

    localparam int AW = 32;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [3:0]          req;
    logic [3:0]          rd_nwr;
    logic [4*AW-1:0]     req_addr;
    logic [4*NODE_W-1:0] req_wdata;
    logic [3:0]          grant;
    logic [3:0]          done;
    logic                err;
    logic [NODE_W-1:0]   rdata;
    logic                bus_req;
    logic                bus_we;
    logic [AW-1:0]       bus_addr;
    logic [31:0]         bus_wdata;
    logic                bus_ack = 1'b0;
    logic [31:0]         bus_rdata = '0;

    t05_sram_arbiter #(.ADDR_W(AW), .NODE_W(NODE_W), .TIMEOUT(255)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .rd_nwr    (rd_nwr),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .grant     (grant),
        .done      (done),
        .err       (err),
        .rdata     (rdata),
        .bus_req   (bus_req),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_ack   (bus_ack),
        .bus_rdata (bus_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] data;
    } beat_t;

    typedef struct {
        logic [3:0]        done;
        logic              err;
        logic [NODE_W-1:0] rdata;
        int                cyc;
    } resp_t;

    beat_t             exp_bus[$];
    resp_t             exp_done[$];
    beat_t             b_mon;
    resp_t             r_mon;
    int                n_checks = 0;
    int                n_fail   = 0;
    int                cyc      = 0;
    int                waits    = 0;
    int                wcnt     = 0;
    bit                ack_stuck = 1'b0;
    int                start;
    int                n;
    logic [31:0]       mem [logic [31:0]];
    logic [NODE_W-1:0] model_rdata = '0;
    logic [31:0]       c_addr [4];
    logic [NODE_W-1:0] c_wd [4];
    int                order [5] = '{0, 1, 2, 3, 0};

    task automatic check(input string name, input logic [NODE_W-1:0] act, input logic [NODE_W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Bus slave: acks after 'waits' idle cycles per beat, or never when stuck.
    always @(negedge clk) begin
        if (bus_req && !ack_stuck && wcnt >= waits) begin
            bus_ack   = 1'b1;
            bus_rdata = mem.exists(bus_addr) ? mem[bus_addr] : 32'hDEAD_BEEF;
            wcnt      = 0;
        end else begin
            bus_ack = 1'b0;
            wcnt    = bus_req ? wcnt + 1 : 0;
        end
    end

    initial forever begin
        @(negedge clk);
        #1;
        if (rst_n) begin
            if (grant != 4'd0) check("grant_onehot", NODE_W'($onehot(grant)), NODE_W'(1));
            if (bus_req && bus_ack) begin
                if (exp_bus.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_beat: got addr %h, expected no beat", bus_addr);
                end else begin
                    b_mon = exp_bus.pop_front();
                    check("beat_addr", bus_addr, b_mon.addr);
                    check("beat_we", bus_we, b_mon.we);
                    if (b_mon.we) check("beat_wdata", bus_wdata, b_mon.data);
                end
            end
            if (done != 4'd0) begin
                if (exp_done.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_done: got %b, expected none", done);
                end else begin
                    r_mon = exp_done.pop_front();
                    check("done_vec", done, r_mon.done);
                    check("done_err", err, r_mon.err);
                    check("done_rdata", rdata, r_mon.rdata);
                    check("done_bus_req", bus_req, 0);
                    check("done_cycle", NODE_W'(cyc), NODE_W'(r_mon.cyc));
                end
            end
        end
    end

    task automatic set_req(input int i, input bit rd, input logic [31:0] a, input logic [NODE_W-1:0] w);
        rd_nwr[i]                    = rd;
        req_addr[i*AW +: AW]         = a;
        req_wdata[i*NODE_W +: NODE_W] = w;
        req[i]                       = 1'b1;
    endtask

    task automatic push_beats(input logic [31:0] a, input bit we, input logic [NODE_W-1:0] w);
        exp_bus.push_back('{a, we, w[31:0]});
        exp_bus.push_back('{a + 32'd4, we, w[63:32]});
        exp_bus.push_back('{a + 32'd8, we, {25'd0, w[70:64]}});
    endtask

    task automatic wait_done(input int i, input int budget, input bit drop);
        int k = 0;
        while (done[i] !== 1'b1 && k < budget) begin
            @(negedge clk);
            #1;
            k++;
        end
        if (done[i] !== 1'b1) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_done_%0d: got no done within %0d cycles, expected a pulse", i, budget);
        end else if (drop) begin
            req[i] = 1'b0;
        end
    endtask

    task automatic idle_gap();
        @(negedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        req       = '0;
        rd_nwr    = '0;
        req_addr  = '0;
        req_wdata = '0;
        mem[32'h200] = 32'h1111_1111;
        mem[32'h204] = 32'h2222_2222;
        mem[32'h208] = 32'h7FFF_FFFF;
        mem[32'h300] = 32'hA5A5_A5A5;
        mem[32'h304] = 32'h5A5A_5A5A;
        mem[32'h308] = 32'hFFFF_FF81;

        repeat (2) @(negedge clk);
        #1;
        check("rst_grant", grant, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_bus_req", bus_req, 0);
        check("rst_bus_we", bus_we, 0);
        check("rst_bus_addr", bus_addr, 0);
        check("rst_bus_wdata", bus_wdata, 0);
        check("rst_rdata", rdata, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;

        // Write from hTree, zero wait states.
        waits = 0;
        start = cyc;
        exp_bus.push_back('{32'h100, 1'b1, 32'h89AB_CDEF});
        exp_bus.push_back('{32'h104, 1'b1, 32'h0123_4567});
        exp_bus.push_back('{32'h108, 1'b1, 32'h0000_0040});
        exp_done.push_back('{4'b0001, 1'b0, model_rdata, start + 4});
        set_req(REQ_HTREE, 1'b0, 32'h100, 71'h40_0123_4567_89AB_CDEF);
        wait_done(REQ_HTREE, 50, 1'b1);
        idle_gap();

        // Read from FLV with two wait states per beat.
        waits = 2;
        start = cyc;
        model_rdata = {7'h7F, 64'h2222_2222_1111_1111};
        push_beats(32'h200, 1'b0, '0);
        exp_done.push_back('{4'b0010, 1'b0, model_rdata, start + 10});
        set_req(REQ_FLV, 1'b1, 32'h200, '0);
        wait_done(REQ_FLV, 50, 1'b1);
        idle_gap();

        // Codebook read with ack stuck low: abort after 255 waiting cycles, rdata held.
        ack_stuck = 1'b1;
        start = cyc;
        exp_done.push_back('{4'b0100, 1'b1, model_rdata, start + 256});
        set_req(REQ_CB, 1'b1, 32'h400, '0);
        wait_done(REQ_CB, 400, 1'b1);
        ack_stuck = 1'b0;
        idle_gap();

        // Histogram read interrupted by reset during beat1, then re-granted after release.
        waits = 3;
        exp_bus.push_back('{32'h300, 1'b0, 32'h0});
        set_req(REQ_HIST, 1'b1, 32'h300, '0);
        n = 0;
        while (!(bus_req && bus_addr == 32'h304) && n < 40) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("rst_mid_reached_beat1", bus_addr, 32'h304);
        rst_n = 1'b0;
        #1;
        check("rst_mid_grant", grant, 0);
        check("rst_mid_done", done, 0);
        check("rst_mid_err", err, 0);
        check("rst_mid_bus_req", bus_req, 0);
        check("rst_mid_bus_we", bus_we, 0);
        check("rst_mid_bus_addr", bus_addr, 0);
        check("rst_mid_bus_wdata", bus_wdata, 0);
        check("rst_mid_rdata", rdata, 0);
        check("rst_mid_beats_left", NODE_W'(exp_bus.size()), 0);
        model_rdata = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        start = cyc;
        model_rdata = {7'h01, 64'h5A5A_5A5A_A5A5_A5A5};
        push_beats(32'h300, 1'b0, '0);
        exp_done.push_back('{4'b1000, 1'b0, model_rdata, start + 13});
        wait_done(REQ_HIST, 60, 1'b1);
        idle_gap();

        // All four requesting with the pointer at 0: grants 0,1,2,3,0.
        waits = 0;
        for (int i = 0; i < 4; i++) begin
            c_addr[i] = 32'h1000 + 32'(i * 32'h100);
            c_wd[i]   = {7'(16 + i), 32'(32'hC0DE_0000 + i), 32'(32'hF00D_0000 + i)};
            rd_nwr[i] = 1'b0;
            req_addr[i*AW +: AW] = c_addr[i];
            req_wdata[i*NODE_W +: NODE_W] = c_wd[i];
        end
        start = cyc;
        for (int k = 0; k < 5; k++) begin
            push_beats(c_addr[order[k]], 1'b1, c_wd[order[k]]);
            exp_done.push_back('{4'(1 << order[k]), 1'b0, model_rdata, start + 4 + 5 * k});
        end
        req = 4'b1111;
        for (int k = 0; k < 5; k++) wait_done(order[k], 40, 1'b0);
        req = 4'b0000;
        idle_gap();

        // hTree write whose req falls during beat0 still completes all beats.
        waits = 1;
        start = cyc;
        exp_bus.push_back('{32'h500, 1'b1, 32'hCCCC_DDDD});
        exp_bus.push_back('{32'h504, 1'b1, 32'hAAAA_BBBB});
        exp_bus.push_back('{32'h508, 1'b1, 32'h0000_0055});
        exp_done.push_back('{4'b0001, 1'b0, model_rdata, start + 7});
        set_req(REQ_HTREE, 1'b0, 32'h500, 71'h55_AAAA_BBBB_CCCC_DDDD);
        idle_gap();
        check("drop_grant", grant, 4'b0001);
        req[REQ_HTREE] = 1'b0;
        wait_done(REQ_HTREE, 40, 1'b0);
        idle_gap();

        repeat (3) idle_gap();
        check("end_beats_left", NODE_W'(exp_bus.size()), 0);
        check("end_dones_left", NODE_W'(exp_done.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
